// File: rtl/display_anim_scheduler.sv
// Shares one seven-segment display between three round-robin animation requesters
// and the idle banner, and generates the per-owner step index from a us/ms/step timebase.
module display_anim_scheduler #(
  parameter int CLOCK_MHZ = 50,
  parameter int US_PER_MS = 1000,
  parameter int STEP_MS   = 500,
  parameter int LEN0      = 20,
  parameter int LEN1      = 8,
  parameter int LEN2      = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic [2:0] req_n,
  input  logic       idle_msg,
  output logic [1:0] grant,
  output logic [4:0] step,
  output logic       step_stb,
  output logic       busy,
  output logic       done,
  output logic       idle_sel
);

  localparam int US_W = (CLOCK_MHZ > 1) ? $clog2(CLOCK_MHZ) : 1;
  localparam int MS_W = (US_PER_MS > 1) ? $clog2(US_PER_MS) : 1;
  localparam int ST_W = (STEP_MS > 1) ? $clog2(STEP_MS) : 1;

  generate
    if (LEN0 < 2 || LEN0 > 32) begin : g_len0_bad
      $error("LEN0 must be in 2..32");
    end
    if (LEN1 < 2 || LEN1 > 32) begin : g_len1_bad
      $error("LEN1 must be in 2..32");
    end
    if (LEN2 < 2 || LEN2 > 32) begin : g_len2_bad
      $error("LEN2 must be in 2..32");
    end
    if (CLOCK_MHZ < 1 || US_PER_MS < 1 || STEP_MS < 1) begin : g_tb_bad
      $error("timebase parameters must be at least 1");
    end
  endgenerate

  typedef enum logic [0:0] {IDLE, RUN} state_t;

  state_t          state;
  logic [2:0]      req_n_meta;
  logic [2:0]      req_n_sync;
  logic            idle_meta;
  logic [1:0]      ptr;
  logic [US_W-1:0] us_cnt;
  logic [MS_W-1:0] ms_cnt;
  logic [ST_W-1:0] st_cnt;

  logic [2:0] req;
  logic       any_req;
  logic [1:0] c0;
  logic [1:0] c1;
  logic [1:0] c2;
  logic [1:0] winner;
  logic       us_last;
  logic       ms_last;
  logic       st_last;
  logic       tick;
  logic [4:0] cur_last;

  // Two-flop synchronisers; requests idle high so a cleared sync stage means "no request".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_n_meta <= 3'b111;
      req_n_sync <= 3'b111;
      idle_meta  <= 1'b0;
      idle_sel   <= 1'b0;
    end else if (clr) begin
      req_n_meta <= 3'b111;
      req_n_sync <= 3'b111;
      idle_meta  <= 1'b0;
      idle_sel   <= 1'b0;
    end else begin
      req_n_meta <= req_n;
      req_n_sync <= req_n_meta;
      idle_meta  <= idle_msg;
      idle_sel   <= idle_meta;
    end
  end

  assign req     = ~req_n_sync;
  assign any_req = |req;

  function automatic logic [1:0] rr_next(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Search order ptr+1, ptr+2, ptr: the last owner is always the lowest priority.
  always_comb begin
    c0     = rr_next(ptr);
    c1     = rr_next(c0);
    c2     = rr_next(c1);
    winner = c2;
    if (req[c1]) winner = c1;
    if (req[c0]) winner = c0;
  end

  assign us_last = (us_cnt == US_W'(CLOCK_MHZ - 1));
  assign ms_last = (ms_cnt == MS_W'(US_PER_MS - 1));
  assign st_last = (st_cnt == ST_W'(STEP_MS - 1));
  assign tick    = (state == RUN) && us_last && ms_last && st_last;

  always_comb begin
    cur_last = 5'd0;
    case (grant)
      2'd1:    cur_last = 5'(LEN0 - 1);
      2'd2:    cur_last = 5'(LEN1 - 1);
      2'd3:    cur_last = 5'(LEN2 - 1);
      default: cur_last = 5'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= 2'd0;
      step     <= 5'd0;
      step_stb <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ptr      <= 2'd2;
      us_cnt   <= '0;
      ms_cnt   <= '0;
      st_cnt   <= '0;
    end else if (clr) begin
      state    <= IDLE;
      grant    <= 2'd0;
      step     <= 5'd0;
      step_stb <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ptr      <= 2'd2;
      us_cnt   <= '0;
      ms_cnt   <= '0;
      st_cnt   <= '0;
    end else begin
      step_stb <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          us_cnt <= '0;
          ms_cnt <= '0;
          st_cnt <= '0;
          if (any_req) begin
            state <= RUN;
            grant <= winner + 2'd1;
            busy  <= 1'b1;
            ptr   <= winner;
            step  <= 5'd0;
          end
        end
        RUN: begin
          // Every grant change happens on a tick, where all three counters wrap to 0,
          // so the next owner always starts with a full step period.
          us_cnt <= us_last ? '0 : us_cnt + US_W'(1);
          if (us_last) ms_cnt <= ms_last ? '0 : ms_cnt + MS_W'(1);
          if (us_last && ms_last) st_cnt <= st_last ? '0 : st_cnt + ST_W'(1);
          if (tick) begin
            step_stb <= 1'b1;
            if (step != cur_last) begin
              step <= step + 5'd1;
            end else begin
              step <= 5'd0;
              if (!any_req) begin
                state <= IDLE;
                grant <= 2'd0;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else if (winner != ptr) begin
                grant <= winner + 2'd1;
                ptr   <= winner;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_display_anim_scheduler.sv
// Directed bench for display_anim_scheduler: a vector table for a held/released request,
// then hand sequences for switching, round-robin, clr and asynchronous reset.
module tb_display_anim_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic [2:0] req_n;
  logic       idle_msg;
  logic [1:0] grant;
  logic [4:0] step;
  logic       step_stb;
  logic       busy;
  logic       done;
  logic       idle_sel;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] req_n;
    int         wait_n;
    logic [1:0] grant;
    logic [4:0] step;
    logic       stb;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs[13];

  display_anim_scheduler #(
    .CLOCK_MHZ(2),
    .US_PER_MS(2),
    .STEP_MS  (2),
    .LEN0     (4),
    .LEN1     (3),
    .LEN2     (5)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .req_n   (req_n),
    .idle_msg(idle_msg),
    .grant   (grant),
    .step    (step),
    .step_stb(step_stb),
    .busy    (busy),
    .done    (done),
    .idle_sel(idle_sel)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [1:0] g, input logic [4:0] s,
                         input logic stb, input logic b, input logic d);
    chk({tag, "_grant"}, 32'(grant), 32'(g));
    chk({tag, "_step"}, 32'(step), 32'(s));
    chk({tag, "_stb"}, 32'(step_stb), 32'(stb));
    chk({tag, "_busy"}, 32'(busy), 32'(b));
    chk({tag, "_done"}, 32'(done), 32'(d));
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_n = 3'b111;
    clr   = 1'b0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  initial begin
    int stb_seen;
    int grant_seen;

    // req0 held from IDLE, then released after two passes' worth of steps
    vecs[0]  = '{3'b110, 2, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{3'b110, 1, 2'd1, 5'd0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{3'b110, 7, 2'd1, 5'd0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{3'b110, 1, 2'd1, 5'd1, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{3'b110, 1, 2'd1, 5'd1, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{3'b110, 7, 2'd1, 5'd2, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{3'b110, 8, 2'd1, 5'd3, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{3'b110, 8, 2'd1, 5'd0, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{3'b110, 8, 2'd1, 5'd1, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{3'b111, 8, 2'd1, 5'd2, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{3'b111, 8, 2'd1, 5'd3, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{3'b111, 8, 2'd0, 5'd0, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{3'b111, 1, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0};

    rst_n    = 1'b0;
    clr      = 1'b0;
    req_n    = 3'b111;
    idle_msg = 1'b0;
    cyc(2);
    chk_out("reset", 2'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("reset_idle_sel", 32'(idle_sel), 32'd0);
    rst_n = 1'b1;

    // idle banner select: two-cycle synchroniser, no steps without requests
    idle_msg = 1'b1;
    cyc(1);
    chk("idle_sel_1cyc", 32'(idle_sel), 32'd0);
    cyc(1);
    chk("idle_sel_2cyc", 32'(idle_sel), 32'd1);
    stb_seen   = 0;
    grant_seen = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      if (step_stb !== 1'b0) stb_seen++;
      if (grant !== 2'd0 || step !== 5'd0) grant_seen++;
    end
    chk("idle_no_stb", 32'(stb_seen), 32'd0);
    chk("idle_no_grant", 32'(grant_seen), 32'd0);
    idle_msg = 1'b0;
    cyc(1);
    chk("idle_sel_hold", 32'(idle_sel), 32'd1);
    cyc(1);
    chk("idle_sel_fall", 32'(idle_sel), 32'd0);

    for (int i = 0; i < 13; i++) begin
      req_n = vecs[i].req_n;
      cyc(vecs[i].wait_n);
      chk_out($sformatf("vec%0d", i), vecs[i].grant, vecs[i].step, vecs[i].stb,
              vecs[i].busy, vecs[i].done);
    end

    // switching: req2 arrives at step 1 of requester 0's pass (pointer is 0 here)
    req_n = 3'b110;
    cyc(3);
    chk_out("sw_grant", 2'd1, 5'd0, 1'b0, 1'b1, 1'b0);
    cyc(8);
    chk_out("sw_step1", 2'd1, 5'd1, 1'b1, 1'b1, 1'b0);
    req_n = 3'b010;
    cyc(8);
    chk_out("sw_step2", 2'd1, 5'd2, 1'b1, 1'b1, 1'b0);
    cyc(8);
    chk_out("sw_step3", 2'd1, 5'd3, 1'b1, 1'b1, 1'b0);
    cyc(8);
    chk_out("sw_switch", 2'd3, 5'd0, 1'b1, 1'b1, 1'b0);
    cyc(7);
    chk_out("sw_gap", 2'd3, 5'd0, 1'b0, 1'b1, 1'b0);
    cyc(1);
    chk_out("sw_r2s1", 2'd3, 5'd1, 1'b1, 1'b1, 1'b0);
    cyc(24);
    chk_out("sw_r2s4", 2'd3, 5'd4, 1'b1, 1'b1, 1'b0);
    req_n = 3'b111;
    cyc(8);
    chk_out("sw_done", 2'd0, 5'd0, 1'b1, 1'b0, 1'b1);
    cyc(1);
    chk_out("sw_done_off", 2'd0, 5'd0, 1'b0, 1'b0, 1'b0);

    // round-robin from reset with all three requesting
    do_reset();
    req_n = 3'b000;
    cyc(3);
    chk("rr_first", 32'(grant), 32'd1);
    cyc(31);
    chk_out("rr_hold1", 2'd1, 5'd3, 1'b0, 1'b1, 1'b0);
    cyc(1);
    chk_out("rr_second", 2'd2, 5'd0, 1'b1, 1'b1, 1'b0);
    cyc(23);
    chk_out("rr_hold2", 2'd2, 5'd2, 1'b0, 1'b1, 1'b0);
    cyc(1);
    chk_out("rr_third", 2'd3, 5'd0, 1'b1, 1'b1, 1'b0);
    cyc(40);
    chk_out("rr_fourth", 2'd1, 5'd0, 1'b1, 1'b1, 1'b0);

    // clr at step 2 with requests still held
    cyc(16);
    chk_out("clr_pre", 2'd1, 5'd2, 1'b1, 1'b1, 1'b0);
    clr = 1'b1;
    cyc(1);
    chk_out("clr_edge", 2'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    clr = 1'b0;
    cyc(2);
    chk("clr_resync", 32'(grant), 32'd0);
    cyc(1);
    chk_out("clr_regrant", 2'd1, 5'd0, 1'b0, 1'b1, 1'b0);
    cyc(7);
    chk_out("clr_gap", 2'd1, 5'd0, 1'b0, 1'b1, 1'b0);
    cyc(1);
    chk_out("clr_step1", 2'd1, 5'd1, 1'b1, 1'b1, 1'b0);

    // asynchronous reset between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 2'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    req_n = 3'b111;
    cyc(1);
    rst_n = 1'b1;
    cyc(3);
    chk_out("post_rst", 2'd0, 5'd0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/display_anim_scheduler.md
Name: display_anim_scheduler

Overview:
- Schedules the shared 28-bit seven-segment display between three animation requesters (active-low push-buttons 0..2) and the idle banner.
- Generates the step timebase (1 us -> 1 ms -> step period) and a per-requester step index.
- Round-robin arbitration; a granted animation always finishes its current pass before the display can change owner.
- Downstream pattern ROM consumes grant and step and drives the segments.

Parameters:
- CLOCK_MHZ, 50, clk cycles per microsecond
- US_PER_MS, 1000, microseconds per millisecond tick (reduced in simulation)
- STEP_MS, 500, milliseconds per animation step
- LEN0, 20, pass length of animation 0 (legal range 2..32)
- LEN1, 8, pass length of animation 1 (legal range 2..32)
- LEN2, 12, pass length of animation 2 (legal range 2..32)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- clr  in  1  synchronous clear (slide switch), active high
- req_n  in  3  animation requests, active low, asynchronous to clk
- idle_msg  in  1  idle banner select, asynchronous
- grant  out  2  0 = idle/banner, 1..3 = requester 0..2 owns display
- step  out  5  current step index within the pass
- step_stb  out  1  one-cycle pulse on every step advance
- busy  out  1  high while grant != 0
- done  out  1  one-cycle pulse when the scheduler returns to IDLE
- idle_sel  out  1  synchronised idle_msg

Interface (already decided): one clock; reset is asynchronous and active-low.

Behaviour:
- Reset (rst_n low, asynchronous):
  - outputs: grant=0, step=0, step_stb=0, busy=0, done=0, idle_sel=0.
  - internal: prescalers=0, state=IDLE, round-robin pointer=2, so requester 0 is favoured first.
- clr (synchronous, highest priority): same values as reset, applied on the next edge.
- req_n and idle_msg pass through 2-flop synchronisers.
  - req[i] = ~req_n_sync[i]. Total latency from a pin edge to the arbiter is 2 cycles.
- Timebase:
  - Microsecond counter wraps every CLOCK_MHZ cycles. The millisecond counter counts US_PER_MS microsecond wraps. The step counter counts STEP_MS millisecond wraps.
  - step_stb is high for exactly one cycle per period: CLOCK_MHZ*US_PER_MS*STEP_MS cycles.
  - All three counters are held at 0 in IDLE and are cleared on every grant change. The first step_stb after a grant change therefore comes one full period later.
- Arbiter: search order starts at pointer+1 mod 3. The first asserted req wins, and the pointer is set to the winner.
- IDLE state:
  - grant=0, step=0.
  - The cycle any req is seen, the next edge loads grant=winner+1, step=0, state=RUN.
- RUN state, on step_stb with step < LEN(g)-1: step increments by 1.
- RUN state, on step_stb with step == LEN(g)-1 (end of pass):
  - Another requester asserted: re-arbitrate from the current pointer. The current owner has lowest priority. Load the new grant, step=0, stay in RUN.
  - Only the current owner asserted: step wraps to 0 and grant is unchanged.
  - No requester asserted: state=IDLE, grant=0, step=0, done=1 for that cycle.
- Release or new requests mid-pass have no effect until the end of the pass. An animation is never truncated.
- Simultaneous requests from IDLE are resolved by the pointer. After reset, req0..2 all asserted grants requester 0.
- Step width is 5 bits. LEN values outside 2..32 are illegal; check them in elaboration/assertion.
- busy = (grant != 0), registered with grant.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Bench parameters: CLOCK_MHZ=2, US_PER_MS=2, STEP_MS=2 (step period 8 cycles), LEN0=4, LEN1=3, LEN2=5.
- rst_n low, then high with no requests -> grant=0, step=0, no step_stb for 100 cycles, idle_sel follows idle_msg after 2 cycles.
- req_n=110 held -> grant=1 three edges after the pin edge; step_stb every 8 cycles; step 0,1,2,3,0,1... continuously.
- req_n=110 for 10 cycles then released -> pass completes (step reaches 3); then grant=0 and done=1 for exactly one cycle, coincident with the 4th step_stb.
- Switching: req0 held, req2 asserted at step 1 -> grant stays 1 until the end of the pass; then grant=3, step=0. Next step_stb is 8 cycles later; sequence 0..4.
- req_n=000 from IDLE after reset -> grant order 1,2,3,1 at successive pass ends (round-robin fairness).
- clr pulsed mid-RUN at step 2 -> next edge grant=0, step=0, prescalers cleared. With req still held, re-grant to requester 0.
- Async rst_n assert mid-cycle during RUN -> outputs go to reset values immediately, without waiting for a clock edge.
